// File: rtl/nco_wave_interp_if.sv
// Stream and table-write signals between the NCO front end and the interpolator.
// The master side offers phases, writes tables and consumes samples; the slave
// side is the interpolator itself.
interface nco_wave_interp_if #(
  parameter int PHASE_W  = 32,
  parameter int IDX_W    = 5,
  parameter int SAMPLE_W = 16
);
  // Phase input stream
  logic                       phase_valid;
  logic [PHASE_W-1:0]         phase;
  logic                       phase_ready;

  // Run-time table write port
  logic                       tbl_we;
  logic [IDX_W-1:0]           tbl_addr;
  logic signed [SAMPLE_W-1:0] tbl_wave;
  logic signed [SAMPLE_W-1:0] tbl_slope;

  // Sample output stream
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample;
  logic                       sample_ready;

  modport master (
    output phase_valid, phase, tbl_we, tbl_addr, tbl_wave, tbl_slope, sample_ready,
    input  phase_ready, sample_valid, sample
  );

  modport slave (
    input  phase_valid, phase, tbl_we, tbl_addr, tbl_wave, tbl_slope, sample_ready,
    output phase_ready, sample_valid, sample
  );
endinterface

// File: rtl/nco_wave_interp.sv
// Wavetable interpolator behind the NCO phase accumulator.
// The top IDX_W phase bits select a waveform entry and its slope; the next
// FRAC_W bits scale the slope. Three stages (lookup, multiply, add+saturate)
// advance together under a single enable, so bubbles are kept and order is
// preserved. Tables are writable at any time, independent of the enable.
module nco_wave_interp #(
  parameter int PHASE_W  = 32,
  parameter int IDX_W    = 5,
  parameter int FRAC_W   = 11,
  parameter int SAMPLE_W = 16
) (
  input logic               master_clk,
  input logic               rst,
  nco_wave_interp_if.slave  bus
);

  localparam int DEPTH  = 1 << IDX_W;
  localparam int PROD_W = SAMPLE_W + FRAC_W + 1;
  localparam int SUM_W  = SAMPLE_W + 1;

  // Tables
  logic signed [SAMPLE_W-1:0] wave_q  [DEPTH];
  logic signed [SAMPLE_W-1:0] slope_q [DEPTH];

  // Pipeline state
  logic                       v1_q, v2_q, v3_q;
  logic [FRAC_W-1:0]          frac1_q;
  logic signed [SAMPLE_W-1:0] wave1_q, slope1_q;
  logic signed [SAMPLE_W-1:0] wave2_q;
  logic signed [PROD_W-1:0]   prod2_q;
  logic signed [SAMPLE_W-1:0] sample_q;

  // Combinational next-state values
  logic [IDX_W-1:0]           idx_d;
  logic [FRAC_W-1:0]          frac_d;
  logic signed [PROD_W-1:0]   prod_d;
  logic signed [SUM_W-1:0]    sum_d;
  logic signed [SAMPLE_W-1:0] sample_d;
  logic                       en;

  // Phase bits below the fraction are truncated on purpose.
  logic unused_phase_lsbs;
  assign unused_phase_lsbs = ^bus.phase[PHASE_W-IDX_W-FRAC_W-1:0];

  assign idx_d  = bus.phase[PHASE_W-1 -: IDX_W];
  assign frac_d = bus.phase[PHASE_W-IDX_W-1 -: FRAC_W];

  // Whole pipeline moves when the output slot is empty or being drained.
  assign en               = !v3_q || bus.sample_ready;
  assign bus.phase_ready  = en;
  assign bus.sample_valid = v3_q;
  assign bus.sample       = sample_q;

  // Table storage: cleared on reset, written whenever tbl_we is high.
  // NOTE: the tables must read back as zero after reset, so they are built
  // from resettable flops rather than a RAM macro that could not be cleared.
  // A same-edge write and S1 read of one address naturally yields the old value.
  always_ff @(posedge master_clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        wave_q[i]  <= '0;
        slope_q[i] <= '0;
      end
    end else if (bus.tbl_we) begin
      wave_q[bus.tbl_addr]  <= bus.tbl_wave;
      slope_q[bus.tbl_addr] <= bus.tbl_slope;
    end
  end

  // Multiply and add/saturate datapath between the stage registers.
  // NOTE: every output is assigned a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    prod_d   = '0;
    sum_d    = '0;
    sample_d = sample_q;

    prod_d = slope1_q * $signed({1'b0, frac1_q});
    // Arithmetic shift floors negative products toward minus infinity.
    sum_d  = SUM_W'(wave2_q) + SUM_W'(prod2_q >>> FRAC_W);

    if (sum_d[SUM_W-1] != sum_d[SUM_W-2]) begin
      sample_d = sum_d[SUM_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else begin
      sample_d = sum_d[SAMPLE_W-1:0];
    end
  end

  // Three lock-step pipeline stages: lookup, multiply, add+saturate.
  // NOTE: stage registers use non-blocking assignments so each stage reads the
  // value its predecessor held before this edge, not the one being written.
  always_ff @(posedge master_clk) begin
    if (!rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      frac1_q  <= '0;
      wave1_q  <= '0;
      slope1_q <= '0;
      wave2_q  <= '0;
      prod2_q  <= '0;
      sample_q <= '0;
    end else if (en) begin
      v1_q     <= bus.phase_valid;
      frac1_q  <= frac_d;
      wave1_q  <= wave_q[idx_d];
      slope1_q <= slope_q[idx_d];
      v2_q     <= v1_q;
      wave2_q  <= wave1_q;
      prod2_q  <= prod_d;
      v3_q     <= v2_q;
      sample_q <= sample_d;
    end
  end

endmodule

// File: tb/tb_nco_wave_interp.sv
// Directed bench for nco_wave_interp. Expected samples are queued when a phase
// is accepted and compared in order when the DUT hands a sample over.
module tb_nco_wave_interp;

  typedef struct {
    int    value;
    string tag;
  } exp_t;

  logic master_clk = 1'b0;
  logic rst        = 1'b0;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  nco_wave_interp_if bus ();

  nco_wave_interp dut (
    .master_clk (master_clk),
    .rst        (rst),
    .bus        (bus)
  );

  always #5 master_clk = ~master_clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_phase(input int idx, input int frac);
    logic [31:0] i32, f32;
    i32 = 32'(idx);
    f32 = 32'(frac);
    return (i32 << 27) | (f32 << 16);
  endfunction

  // Output-side scoreboard: sample away from the rising edge.
  always @(negedge master_clk) begin
    if (rst && bus.sample_valid && bus.sample_ready) begin
      check("sample_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check(mon_e.tag, $signed(bus.sample), mon_e.value);
      end
    end
  end

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic wr(input int addr, input int wave, input int slope);
    bus.tbl_we    = 1'b1;
    bus.tbl_addr  = 5'(addr);
    bus.tbl_wave  = 16'(wave);
    bus.tbl_slope = 16'(slope);
    @(posedge master_clk); #1;
    bus.tbl_we    = 1'b0;
  endtask

  task automatic send(input logic [31:0] ph, input int value, input string tag,
                      input bit expect_out);
    int budget = 0;
    bus.phase_valid = 1'b1;
    bus.phase       = ph;
    #1;
    while (!bus.phase_ready && budget < 64) begin
      @(posedge master_clk); #2;
      budget++;
    end
    check({tag, " phase_ready"}, 32'(bus.phase_ready), 1);
    if (expect_out) exp_q.push_back('{value: value, tag: tag});
    @(posedge master_clk); #1;
    bus.phase_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge master_clk); #1;
      budget++;
    end
    check({tag, " drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    bus.phase_valid  = 1'b0;
    bus.phase        = '0;
    bus.tbl_we       = 1'b0;
    bus.tbl_addr     = '0;
    bus.tbl_wave     = '0;
    bus.tbl_slope    = '0;
    bus.sample_ready = 1'b1;

    // Reset
    repeat (2) @(posedge master_clk);
    #1 rst = 1'b1;
    #1;
    check("reset sample_valid", 32'(bus.sample_valid), 0);
    check("reset sample", $signed(bus.sample), 0);
    check("reset phase_ready", 32'(bus.phase_ready), 1);
    @(posedge master_clk); #1;

    // T1: basic lookup and latency
    wr(0, 1000, 2048);
    bus.phase_valid = 1'b1;
    bus.phase       = 32'h0000_0000;
    exp_q.push_back('{value: 1000, tag: "T1 idx0 frac0"});
    @(posedge master_clk); #1;
    bus.phase_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge master_clk);
      lat++;
      if (bus.sample_valid) break;
    end
    check("T1 latency edges", lat, 3);
    @(posedge master_clk); #1;
    drain("T1");

    // T2: interpolation, negative slope, ignored phase LSBs
    send(32'h0400_0000, 2024, "T2 idx0 frac1024", 1'b1);
    send(32'h0400_FFFF, 2024, "T2 truncated LSBs", 1'b1);
    wr(1, -100, -300);
    send(32'h0C00_0000, -250, "T2 idx1 frac1024", 1'b1);
    drain("T2");

    // T3: saturation at both rails and floor of a negative product
    wr(31, 32000, 2000);
    send(32'hFFFF_0000, 32767, "T3 sat high idx31", 1'b1);
    wr(2, -32000, -2000);
    send(32'h17FF_0000, -32768, "T3 sat low idx2", 1'b1);
    wr(3, 0, -1);
    send(mk_phase(3, 1), -1, "T3 floor", 1'b1);
    drain("T3");

    // T4: backpressure with a full pipeline
    wr(5, 0, 80);
    bus.sample_ready = 1'b0;
    send(mk_phase(5, 256), 10, "T4 s10", 1'b1);
    send(mk_phase(5, 512), 20, "T4 s20", 1'b1);
    send(mk_phase(5, 768), 30, "T4 s30", 1'b1);
    bus.phase_valid = 1'b1;
    bus.phase       = mk_phase(5, 1024);
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("T4 stall%0d sample_valid", i), 32'(bus.sample_valid), 1);
      check($sformatf("T4 stall%0d sample", i), $signed(bus.sample), 10);
      check($sformatf("T4 stall%0d phase_ready", i), 32'(bus.phase_ready), 0);
      @(posedge master_clk); #1;
    end
    bus.sample_ready = 1'b1;
    #1;
    check("T4 release phase_ready", 32'(bus.phase_ready), 1);
    exp_q.push_back('{value: 40, tag: "T4 s40"});
    @(posedge master_clk); #1;
    send(mk_phase(5, 1280), 50, "T4 s50", 1'b1);
    drain("T4");

    // T5: write and read of the same entry on the same edge
    bus.tbl_we      = 1'b1;
    bus.tbl_addr    = 5'd4;
    bus.tbl_wave    = 16'sd500;
    bus.tbl_slope   = 16'sd0;
    bus.phase_valid = 1'b1;
    bus.phase       = mk_phase(4, 0);
    exp_q.push_back('{value: 0, tag: "T5 old value"});
    #1;
    check("T5 phase_ready", 32'(bus.phase_ready), 1);
    @(posedge master_clk); #1;
    bus.tbl_we = 1'b0;
    exp_q.push_back('{value: 500, tag: "T5 new value"});
    @(posedge master_clk); #1;
    bus.phase_valid = 1'b0;
    drain("T5");

    // T6: reset with three samples in flight
    bus.sample_ready = 1'b0;
    send(mk_phase(0, 0), 0, "T6 fill0", 1'b0);
    send(mk_phase(1, 0), 0, "T6 fill1", 1'b0);
    send(mk_phase(31, 0), 0, "T6 fill2", 1'b0);
    check("T6 in flight", 32'(bus.sample_valid), 1);
    rst = 1'b0;
    @(posedge master_clk); #1;
    rst = 1'b1;
    check("T6 post-reset sample_valid", 32'(bus.sample_valid), 0);
    check("T6 post-reset sample", $signed(bus.sample), 0);
    bus.sample_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge master_clk); #1;
      check($sformatf("T6 no stale %0d", i), 32'(bus.sample_valid), 0);
    end
    send(mk_phase(0, 1024), 0, "T6 cleared idx0", 1'b1);
    send(mk_phase(31, 2047), 0, "T6 cleared idx31", 1'b1);
    send(mk_phase(5, 1280), 0, "T6 cleared idx5", 1'b1);
    drain("T6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
